// File: rtl/int_to_float_if.sv
// Handshake and data bundle between a requester and the int_to_float converter.
// The master drives the request; the slave (converter) drives the result and status.
interface int_to_float_if;
    logic        start;
    logic [31:0] in_int;
    logic [31:0] Out;
    logic        busy;
    logic        done;
    logic [7:0]  shift;

    modport master (
        output start,
        output in_int,
        input  Out,
        input  busy,
        input  done,
        input  shift
    );

    modport slave (
        input  start,
        input  in_int,
        output Out,
        output busy,
        output done,
        output shift
    );
endinterface

// File: rtl/int_to_float.sv
// Signed 32-bit integer to IEEE-754 single-precision converter.
// Normalises one bit per cycle, then rounds to nearest, ties to even.
module int_to_float (
    input  logic          clk,
    input  logic          rst,
    int_to_float_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound} state_e;

    state_e      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic        sign_q, sign_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] out_q, out_d;
    logic [7:0]  shift_q, shift_d;
    logic        done_q, done_d;

    logic [31:0] abs_in;
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_sum;
    logic [7:0]  exp_val;

    // -2^31 negates to itself, which is exactly the unsigned magnitude 0x80000000.
    assign abs_in = bus.in_int[31] ? (~bus.in_int + 32'd1) : bus.in_int;

    assign mant     = mag_q[30:8];
    assign guard    = mag_q[7];
    assign sticky   = |mag_q[6:0];
    assign round_up = guard & (sticky | mant[0]);
    assign mant_sum = {1'b0, mant} + {23'd0, round_up};
    // Carry out of the mantissa leaves it all-zero and bumps the exponent.
    assign exp_val  = 8'd158 - {3'd0, cnt_q} + {7'd0, mant_sum[23]};

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sign_d = bus.in_int[31];
                    mag_d  = abs_in;
                    cnt_d  = 5'd0;
                    if (abs_in != 32'd0) begin
                        state_d = StNorm;
                    end else begin
                        out_d   = 32'd0;
                        shift_d = 8'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            StNorm: begin
                if (mag_q[31]) begin
                    state_d = StRound;
                end else begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StRound: begin
                out_d   = {sign_q, exp_val, mant_sum[22:0]};
                shift_d = {3'd0, cnt_q};
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mag_q   <= 32'd0;
            sign_q  <= 1'b0;
            cnt_q   <= 5'd0;
            out_q   <= 32'd0;
            shift_q <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    assign bus.Out   = out_q;
    assign bus.shift = shift_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: directed cases plus random inputs
// compared against an arithmetic round-to-nearest-even reference.
module tb_int_to_float;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    int_to_float_if bus ();

    int_to_float dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int msb_pos(input logic [63:0] m);
        int p;
        p = -1;
        for (int i = 0; i < 64; i++) begin
            if (m[i]) p = i;
        end
        return p;
    endfunction

    function automatic logic [63:0] magnitude(input logic [31:0] x);
        return x[31] ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
    endfunction

    // Leading zeros of the 32-bit magnitude (0 for a zero input).
    function automatic int ref_lz(input logic [31:0] x);
        if (x == 32'd0) return 0;
        return 31 - msb_pos(magnitude(x));
    endfunction

    function automatic logic [31:0] ref_float(input logic [31:0] x);
        logic [63:0] m, sig, rem, half;
        int          p, d;
        if (x == 32'd0) return 32'd0;
        m = magnitude(x);
        p = msb_pos(m);
        if (p <= 23) begin
            sig = m << (23 - p);
        end else begin
            d    = p - 23;
            sig  = m >> d;
            rem  = m & ((64'd1 << d) - 64'd1);
            half = 64'd1 << (d - 1);
            if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
            if (sig == (64'd1 << 24)) begin
                sig = sig >> 1;
                p   = p + 1;
            end
        end
        return {x[31], 8'(127 + p), sig[22:0]};
    endfunction

    task automatic run_conv(input logic [31:0] val, input logic [31:0] exp_out,
                            input string tag);
        int exp_lat;
        int lat;
        exp_lat = (val == 32'd0) ? 0 : ref_lz(val) + 2;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.in_int = val;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.in_int = $urandom;
        if (val != 32'd0) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out"}, bus.Out, exp_out);
        check({tag, "_shift"}, 32'(bus.shift), 32'(ref_lz(val)));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 32'(bus.done), 32'd0);
    endtask

    logic [31:0] r;
    int          done_seen;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.in_int = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", bus.Out, 32'd0);
        check("reset_shift", 32'(bus.shift), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_conv(32'd1,         32'h3F800000, "one");
        run_conv(32'd3,         32'h40400000, "three");
        run_conv(-32'sd7,       32'hC0E00000, "minus7");
        run_conv(32'd0,         32'h00000000, "zero");
        run_conv(32'h80000000,  32'hCF000000, "int_min");
        run_conv(32'h01000001,  32'h4B800000, "tie_even");
        run_conv(32'h01000003,  32'h4B800002, "tie_up");
        run_conv(32'h7FFFFFFF,  32'h4F000000, "exp_carry");

        // Start held high: accepted on every IDLE edge, ignored on the done edge.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.in_int = 32'h80000000;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_done_%0d", k), 32'(bus.done), (k % 3 == 2) ? 32'd1 : 32'd0);
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clk);

        // Reset aborts an in-flight conversion; an extra start mid-flight is ignored.
        done_seen = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.in_int = 32'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (e == 5) begin
                bus.start  = 1'b1;
                bus.in_int = 32'd5;
            end
            if (e == 10) rst = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) done_seen++;
            if (e == 5) check("abort_busy_mid", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_out", bus.Out, 32'd0);
        run_conv(32'd5, 32'h40A00000, "after_reset");

        for (int i = 0; i < 10000; i++) begin
            r = $urandom;
            if ($urandom_range(0, 15) == 0) r = r >> $urandom_range(0, 31);
            run_conv(r, ref_float(r), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
